// File: rtl/x_mem_loader_if.sv
// rtl/x_mem_loader_if.sv - sample stream in and x-memory write port for the x loader
interface x_mem_loader_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;

    // master: sample source that also observes the memory write port
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    // slave: the loader itself
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/x_mem_loader.sv
// rtl/x_mem_loader.sv - writes one frame of x samples to addresses 0..DEPTH-1, holds it until released
module x_mem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 361
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         release_in,
    output logic         loaded,
    output logic         busy,
    x_mem_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH-1:0] index_nxt;
    logic                  accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
        end
    end

    // index parks on DEPTH-1 after the last beat; only a new start rewinds it
    always_comb begin
        state_nxt = state;
        index_nxt = index;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    index_nxt = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (index == LAST_IDX) begin
                        state_nxt = FULL;
                    end else begin
                        index_nxt = index + 1'b1;
                    end
                end
            end
            FULL: begin
                if (release_in) begin
                    if (start) begin
                        state_nxt = LOAD;
                        index_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                index_nxt = '0;
            end
        endcase
    end

    // status flags decode the state register, so they change on the same edges as the write port
    assign bus.in_ready = (state == LOAD);
    assign busy         = (state == LOAD);
    assign loaded       = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= accept;
            if (accept) begin
                bus.wr_addr <= index;
                bus.wr_data <= bus.in_data;
            end
        end
    end
endmodule

// File: tb/tb_x_mem_loader.sv
// tb/tb_x_mem_loader.sv - directed self-checking bench for x_mem_loader
module tb_x_mem_loader;
    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 9;
    localparam int DEPTH      = 361;

    logic clk;
    logic rst;
    logic start;
    logic release_in;
    logic loaded;
    logic busy;

    int total;
    int bad;

    x_mem_loader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    x_mem_loader #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .release_in (release_in),
        .loaded     (loaded),
        .busy       (busy),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_in_ready", 64'(bus.in_ready), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_loaded", 64'(loaded), 64'd0);
        chk("start_wr_en", 64'(bus.wr_en), 64'd0);
    endtask

    // nbeats beats with data addr+100; optional 3-cycle stalls after beats sa/sb,
    // a stray start on beat st_at and a stray release on beat rl_at
    task automatic frame(input int nbeats, input int sa, input int sb, input int st_at, input int rl_at);
        for (int k = 0; k < nbeats; k++) begin
            if (k == sa + 1 || k == sb + 1) begin
                bus.in_valid = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    step();
                    chk($sformatf("stall_wr_en_%0d_%0d", k, s), 64'(bus.wr_en), 64'd0);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 32'(k + 100);
            start        = (k == st_at);
            release_in   = (k == rl_at);
            step();
            start      = 1'b0;
            release_in = 1'b0;
            chk($sformatf("wr_en_%0d", k), 64'(bus.wr_en), 64'd1);
            chk($sformatf("wr_addr_%0d", k), 64'(bus.wr_addr), 64'(k));
            chk($sformatf("wr_data_%0d", k), 64'(bus.wr_data), 64'(k + 100));
            chk($sformatf("loaded_%0d", k), 64'(loaded), 64'(k == DEPTH - 1));
            chk($sformatf("busy_%0d", k), 64'(busy), 64'(k != DEPTH - 1));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic after_full(input string tag);
        step();
        chk({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_loaded"}, 64'(loaded), 64'd1);
        chk({tag, "_addr_hold"}, 64'(bus.wr_addr), 64'(DEPTH - 1));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst          = 1'b0;
        start        = 1'b0;
        release_in   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hdead_beef;

        // asynchronous reset mid-cycle, then idle with valid asserted
        #3 rst = 1'b1;
        #1;
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        chk("rst_loaded", 64'(loaded), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("idle_wr_en_%0d", i), 64'(bus.wr_en), 64'd0);
            chk($sformatf("idle_in_ready_%0d", i), 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;

        // full frame, continuous valid
        do_start();
        frame(DEPTH, -10, -10, -1, -1);
        after_full("full1");

        // release together with start: straight back to LOAD
        release_in = 1'b1;
        start      = 1'b1;
        step();
        release_in = 1'b0;
        start      = 1'b0;
        chk("rs_loaded", 64'(loaded), 64'd0);
        chk("rs_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rs_busy", 64'(busy), 64'd1);

        // stalled frame must still start at address 0 and stay contiguous
        frame(DEPTH, 5, 200, -1, -1);
        after_full("full2");

        // start alone and valid in FULL are both ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("full_start_loaded", 64'(loaded), 64'd1);
        chk("full_start_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd7777;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("full_valid_wr_en_%0d", i), 64'(bus.wr_en), 64'd0);
            chk($sformatf("full_valid_loaded_%0d", i), 64'(loaded), 64'd1);
        end
        bus.in_valid = 1'b0;
        chk("full_valid_data_hold", 64'(bus.wr_data), 64'(DEPTH - 1 + 100));

        // release alone returns to IDLE
        release_in = 1'b1;
        step();
        release_in = 1'b0;
        chk("rel_loaded", 64'(loaded), 64'd0);
        chk("rel_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rel_busy", 64'(busy), 64'd0);
        release_in = 1'b1;
        step();
        release_in = 1'b0;
        chk("idle_rel_in_ready", 64'(bus.in_ready), 64'd0);
        chk("idle_rel_loaded", 64'(loaded), 64'd0);

        // stray start at index 50 and stray release at index 60 during LOAD
        do_start();
        frame(DEPTH, -10, -10, 50, 60);
        after_full("full3");

        release_in = 1'b1;
        step();
        release_in = 1'b0;
        do_start();

        // reset mid-frame at index 120
        frame(120, -10, -10, -1, -1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'd999;
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("mid_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("mid_rst_loaded", 64'(loaded), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        bus.in_valid = 1'b0;
        do_start();
        frame(DEPTH, -10, -10, -1, -1);
        after_full("full4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/x_mem_loader.md
Name: x_mem_loader

Overview:
- Write-side counterpart to the LSTM input-address counter.
- Accepts a stream of input samples x over a valid/ready handshake and writes them into the x input memory at sequential addresses 0..DEPTH-1.
- Raises a completion flag when the frame is stored and holds the memory until the forward-propagation side releases it.
- Sits between the host/testbench data source and the x memory that the LSTM read-address counter scans.

Parameters:
- WIDTH, 32, sample data width in bits.
- ADDR_WIDTH, 9, write-address width.
- DEPTH, 361, samples per frame (addresses 0..360). Must satisfy DEPTH <= 2^ADDR_WIDTH and DEPTH >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to begin loading a frame.
- in_valid  input  1  in_data holds a valid sample.
- in_data  input  WIDTH  sample value.
- in_ready  output  1  loader accepts a sample this cycle.
- wr_en  output  1  memory write strobe.
- wr_addr  output  ADDR_WIDTH  memory write address.
- wr_data  output  WIDTH  memory write data.
- loaded  output  1  full frame stored; memory is valid for reading.
- release_in  input  1  single-cycle pulse: reader has finished with the frame.
- busy  output  1  a frame load is in progress.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - state=IDLE, index=0.
  - wr_en=0, wr_addr=0, wr_data=0, loaded=0, busy=0, in_ready=0.
  - Reset mid-frame discards the partial frame; no further writes occur.
- States:
  - IDLE: in_ready=0. start=1 -> LOAD and index<=0.
  - LOAD: in_ready=1 combinationally (in_ready = state==LOAD); busy=1.
    - A beat is accepted when in_valid & in_ready at a rising edge.
    - If index==DEPTH-1 at acceptance, go to FULL on the same edge.
  - FULL: loaded=1, in_ready=0. release_in=1 -> IDLE. release_in=1 together with start=1 -> LOAD directly with index<=0, and loaded drops.
- Write path (registered, 1-cycle latency):
  - On the accepting edge: wr_en<=1, wr_addr<=index, wr_data<=in_data, index<=index+1.
  - On any non-accepting edge: wr_en<=0. wr_addr and wr_data hold their last values.
  - Addresses are strictly sequential with no gaps. in_valid=0 stalls are allowed at any point in LOAD.
- loaded and busy are registered:
  - loaded rises on the edge that accepts beat DEPTH-1, i.e. in the same cycle wr_en presents address DEPTH-1.
  - busy falls on that same edge.
- Boundaries:
  - index never exceeds DEPTH-1. The wrap to 0 happens only via a new start.
  - start is ignored in LOAD and in FULL unless release_in is also asserted in FULL.
  - release_in is ignored in IDLE and LOAD.
  - in_valid outside LOAD produces no write, and the data is not consumed.
- Arithmetic: index is ADDR_WIDTH bits, unsigned, with no overflow under the DEPTH constraint.

Test Plan:
- Reset then idle: assert rst mid-cycle with in_valid=1 and no start -> all outputs 0 immediately; no wr_en over 20 cycles.
- Full frame, continuous valid: start, then 361 beats with data=addr+100 -> wr_en high 361 consecutive cycles, addresses 0..360, data 100..460, loaded=1 from the cycle of address 360, in_ready=0 afterwards.
- Stalls: drop in_valid for 3 cycles after beats 5 and 200 -> wr_en gaps of 3 cycles, addresses still contiguous 0..360, total 361 writes.
- Release and reload: in FULL, pulse release_in together with start -> loaded falls, in_ready=1 next cycle, next write lands at address 0.
- Ignored controls: start during LOAD at index 50 -> index continues 51, 52, ...; release_in during LOAD -> no effect; in_valid in FULL for 10 cycles -> no wr_en.
- Reset mid-operation: rst at index 120 -> wr_en=0 and busy=0 immediately; a following start restarts at address 0 and a full 361-beat frame completes normally.
